// File: rtl/canvas_ctrl_if.sv
// rtl/canvas_ctrl_if.sv - NN word-read port between the inference engine and the canvas
interface canvas_ctrl_if;
  logic        rd_req;
  logic [9:0]  rd_addr;
  logic        rd_ack;
  logic        rd_valid;
  logic [15:0] rd_data;

  modport master (output rd_req, output rd_addr, input rd_ack, input rd_valid, input rd_data);
  modport slave  (input rd_req, input rd_addr, output rd_ack, output rd_valid, output rd_data);
endinterface

// File: rtl/canvas_ctrl.sv
// rtl/canvas_ctrl.sv - 28x28 canvas owner: 3x3 brush stamps, clear sweep, NN read arbitration
// CANVAS_ERASE_EN adds i_erase; an erasing stamp subtracts the brush, floored at zero.
module canvas_ctrl #(
  parameter int          GRID     = 28,
  parameter int          CELL_PX  = 14,
  parameter int          ORIGIN_X = 199,
  parameter int          ORIGIN_Y = 43,
  parameter logic [15:0] INK_MAX  = 16'h07F8,
  parameter logic [15:0] INK_CTR  = 16'h07F8,
  parameter logic [15:0] INK_EDGE = 16'h0200
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_frame_tick,
  input  logic [9:0]   i_cursor_x,
  input  logic [9:0]   i_cursor_y,
  input  logic         i_pen_down,
`ifdef CANVAS_ERASE_EN
  input  logic         i_erase,
`endif
  input  logic         i_clear_req,
  canvas_ctrl_if.slave rd_if,
  output logic         o_busy,
  output logic [15:0]  o_canvas [GRID][GRID]
);

  localparam logic [9:0] X0    = 10'(ORIGIN_X);
  localparam logic [9:0] Y0    = 10'(ORIGIN_Y);
  localparam logic [9:0] PX    = 10'(CELL_PX);
  localparam logic [9:0] SPAN  = 10'(GRID * CELL_PX);
  localparam logic [9:0] G10   = 10'(GRID);
  localparam logic [9:0] CELLS = 10'(GRID * GRID);
  localparam logic [5:0] G6    = 6'(GRID);
  localparam logic [4:0] LAST  = 5'(GRID - 1);

  typedef enum logic [1:0] {S_IDLE, S_STAMP, S_CLEAR} state_t;

  state_t      r_state, w_next;
  logic        r_busy;
  logic [15:0] r_canvas [GRID][GRID];
  logic [4:0]  r_col, r_row, r_clr_col, r_clr_row;
  logic [1:0]  r_dx, r_dy;
  logic        r_rd_valid;
  logic [15:0] r_rd_data;
`ifdef CANVAS_ERASE_EN
  logic        r_erase;
`endif

  logic        w_ack, w_in_win, w_tgt_ok, w_last_step, w_clr_last, w_rd_ok;
  logic [5:0]  w_tc, w_tr;
  logic [4:0]  w_col_idx, w_row_idx, w_rd_col, w_rd_row;
  logic [15:0] w_cur, w_inc, w_add, w_stamp_val;
  logic [16:0] w_sum;
  logic        w_wr_en;
  logic [4:0]  w_wr_col, w_wr_row;
  logic [15:0] w_wr_data;

  assign w_in_win = (i_cursor_x >= X0) && ((i_cursor_x - X0) < SPAN) &&
                    (i_cursor_y >= Y0) && ((i_cursor_y - Y0) < SPAN);

  // Brush offsets are stored 0..2; subtracting 1 turns column -1 into 63, caught by the range test.
  assign w_tc        = 6'(r_col) + 6'(r_dx) - 6'd1;
  assign w_tr        = 6'(r_row) + 6'(r_dy) - 6'd1;
  assign w_tgt_ok    = (w_tc < G6) && (w_tr < G6);
  assign w_col_idx   = w_tgt_ok ? w_tc[4:0] : 5'd0;
  assign w_row_idx   = w_tgt_ok ? w_tr[4:0] : 5'd0;
  assign w_last_step = (r_dx == 2'd2) && (r_dy == 2'd2);
  assign w_clr_last  = (r_clr_col == LAST) && (r_clr_row == LAST);

  assign w_cur = r_canvas[w_col_idx][w_row_idx];
  assign w_inc = (r_dx == 2'd1 && r_dy == 2'd1) ? INK_CTR : INK_EDGE;
  assign w_sum = {1'b0, w_cur} + {1'b0, w_inc};
  assign w_add = (w_sum > {1'b0, INK_MAX}) ? INK_MAX : w_sum[15:0];
`ifdef CANVAS_ERASE_EN
  assign w_stamp_val = r_erase ? ((w_cur > w_inc) ? (w_cur - w_inc) : 16'd0) : w_add;
`else
  assign w_stamp_val = w_add;
`endif

  assign w_ack    = rd_if.rd_req && (r_state != S_CLEAR);
  assign w_rd_ok  = rd_if.rd_addr < CELLS;
  assign w_rd_col = 5'(rd_if.rd_addr % G10);
  assign w_rd_row = 5'(rd_if.rd_addr / G10);

  always_comb begin
    w_next    = r_state;
    w_wr_en   = 1'b0;
    w_wr_col  = r_clr_col;
    w_wr_row  = r_clr_row;
    w_wr_data = 16'd0;
    case (r_state)
      S_IDLE: begin
        if (i_clear_req)
          w_next = S_CLEAR;
        else if (i_frame_tick && i_pen_down && w_in_win)
          w_next = S_STAMP;
      end
      S_STAMP: begin
        // An acknowledged read owns the array this cycle; the step retries next cycle.
        if (!w_ack) begin
          w_wr_en   = w_tgt_ok;
          w_wr_col  = w_col_idx;
          w_wr_row  = w_row_idx;
          w_wr_data = w_stamp_val;
          if (w_last_step)
            w_next = S_IDLE;
        end
        if (i_clear_req)
          w_next = S_CLEAR;
      end
      S_CLEAR: begin
        w_wr_en = 1'b1;
        if (w_clr_last)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < GRID; c++)
        for (int r = 0; r < GRID; r++)
          r_canvas[c][r] <= 16'd0;
      r_col      <= 5'd0;
      r_row      <= 5'd0;
      r_dx       <= 2'd0;
      r_dy       <= 2'd0;
      r_clr_col  <= 5'd0;
      r_clr_row  <= 5'd0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 16'd0;
`ifdef CANVAS_ERASE_EN
      r_erase    <= 1'b0;
`endif
    end else begin
      if (w_wr_en)
        r_canvas[w_wr_col][w_wr_row] <= w_wr_data;

      r_rd_valid <= w_ack;
      if (w_ack)
        r_rd_data <= w_rd_ok ? r_canvas[w_rd_col][w_rd_row] : 16'd0;

      if (r_state == S_IDLE && w_next == S_STAMP) begin
        r_col <= 5'((i_cursor_x - X0) / PX);
        r_row <= 5'((i_cursor_y - Y0) / PX);
        r_dx  <= 2'd0;
        r_dy  <= 2'd0;
`ifdef CANVAS_ERASE_EN
        r_erase <= i_erase;
`endif
      end else if (r_state == S_STAMP && !w_ack) begin
        if (r_dx == 2'd2) begin
          r_dx <= 2'd0;
          r_dy <= r_dy + 2'd1;
        end else begin
          r_dx <= r_dx + 2'd1;
        end
      end

      if (w_next == S_CLEAR && r_state != S_CLEAR) begin
        r_clr_col <= 5'd0;
        r_clr_row <= 5'd0;
      end else if (r_state == S_CLEAR) begin
        if (r_clr_col == LAST) begin
          r_clr_col <= 5'd0;
          r_clr_row <= r_clr_row + 5'd1;
        end else begin
          r_clr_col <= r_clr_col + 5'd1;
        end
      end
    end
  end

  assign o_busy         = r_busy;
  assign o_canvas       = r_canvas;
  assign rd_if.rd_ack   = w_ack;
  assign rd_if.rd_valid = r_rd_valid;
  assign rd_if.rd_data  = r_rd_data;

endmodule

// File: tb/tb_canvas_ctrl.sv
// tb/tb_canvas_ctrl.sv - randomized self-checking bench for canvas_ctrl against a cell-array model
module tb_canvas_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick, pen_down, erase, clear_req, busy;
  logic [9:0]  cursor_x, cursor_y;
  logic [15:0] canvas [28][28];

  canvas_ctrl_if rif ();

  canvas_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_frame_tick (frame_tick),
    .i_cursor_x   (cursor_x),
    .i_cursor_y   (cursor_y),
    .i_pen_down   (pen_down),
`ifdef CANVAS_ERASE_EN
    .i_erase      (erase),
`endif
    .i_clear_req  (clear_req),
    .rd_if        (rif),
    .o_busy       (busy),
    .o_canvas     (canvas)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int m [28][28];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic void model_clear();
    for (int c = 0; c < 28; c++)
      for (int r = 0; r < 28; r++)
        m[c][r] = 0;
  endfunction

  function automatic bit in_win(input int x, input int y);
    return (x >= 199) && (x < 199 + 392) && (y >= 43) && (y < 43 + 392);
  endfunction

  function automatic void model_stamp(input int x, input int y, input bit er);
    int c0, r0;
    c0 = (x - 199) / 14;
    r0 = (y - 43) / 14;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        int c, r, inc;
        c = c0 + dx;
        r = r0 + dy;
        inc = (dx == 0 && dy == 0) ? 'h7F8 : 'h200;
        if (c >= 0 && c < 28 && r >= 0 && r < 28) begin
          if (er) m[c][r] = (m[c][r] > inc) ? m[c][r] - inc : 0;
          else    m[c][r] = (m[c][r] + inc > 'h7F8) ? 'h7F8 : m[c][r] + inc;
        end
      end
  endfunction

  function automatic int model_read(input int addr);
    return (addr < 784) ? m[addr % 28][addr / 28] : 0;
  endfunction

  task automatic compare_canvas(input string tag);
    int nm = 0;
    for (int c = 0; c < 28; c++)
      for (int r = 0; r < 28; r++)
        if (canvas[c][r] !== 16'(m[c][r])) nm++;
    check(tag, nm, 0);
  endtask

  task automatic do_read(input string tag, input int addr);
    int w = 0;
    int want = model_read(addr);
    rif.rd_req  = 1'b1;
    rif.rd_addr = 10'(addr);
    while (!rif.rd_ack && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_ack"}, rif.rd_ack, 1);
    @(negedge clk);
    rif.rd_req = 1'b0;
    check({tag, "_valid"}, rif.rd_valid, 1);
    check({tag, "_data"}, rif.rd_data, want);
    @(negedge clk);
    check({tag, "_pulse"}, rif.rd_valid, 0);
  endtask

  // Reads are held for the first k cycles of the stamp; each one stalls a step before any write lands.
  task automatic stamp_run(input string tag, input int x, input int y, input bit pen,
                           input bit er, input int k, input int raddr);
    int cyc = 0;
    int vc = 0;
    int want_rd = model_read(raddr);
    bit go = pen && in_win(x, y);
    cursor_x = 10'(x);
    cursor_y = 10'(y);
    pen_down = pen;
    erase = er;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    while (busy && cyc < 2000) begin
      rif.rd_req  = (cyc < k);
      rif.rd_addr = 10'(raddr);
      @(negedge clk);
      cyc++;
      if (rif.rd_valid) vc++;
    end
    rif.rd_req = 1'b0;
    check({tag, "_busy_cycles"}, cyc, go ? 9 + k : 0);
    if (go) begin
      check({tag, "_valids"}, vc, k);
      if (k > 0) check({tag, "_rd_data"}, rif.rd_data, want_rd);
      model_stamp(x, y, er);
    end
    compare_canvas({tag, "_canvas"});
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, acks, x, y, k, a;
    bit pen, er;
    rst = 1'b1;
    frame_tick = 1'b0;
    pen_down = 1'b0;
    erase = 1'b0;
    clear_req = 1'b0;
    cursor_x = '0;
    cursor_y = '0;
    rif.rd_req = 1'b0;
    rif.rd_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear();

    check("rst_busy", busy, 0);
    check("rst_valid", rif.rd_valid, 0);
    check("rst_data", rif.rd_data, 0);
    compare_canvas("rst_canvas");
    do_read("rd0", 0);
    do_read("rd783", 783);
    do_read("rd1023", 1023);

    stamp_run("st1", 199 + 14*5 + 3, 43 + 14*7 + 1, 1, 0, 0, 0);
    check("st1_ctr", canvas[5][7], 'h7F8);
    check("st1_nw", canvas[4][6], 'h200);
    check("st1_se", canvas[6][8], 'h200);
    for (int i = 0; i < 2; i++)
      stamp_run("strep", 199 + 14*5 + 3, 43 + 14*7 + 1, 1, 0, 0, 0);
    check("st3_nbr", canvas[6][7], 'h600);
    stamp_run("st4", 199 + 14*5 + 3, 43 + 14*7 + 1, 1, 0, 0, 0);
    check("st4_nbr", canvas[6][7], 'h7F8);
    stamp_run("st5", 199 + 14*5 + 3, 43 + 14*7 + 1, 1, 0, 0, 0);
    check("st5_ctr", canvas[5][7], 'h7F8);

    stamp_run("corner", 199, 43, 1, 0, 0, 0);
    check("corner_00", canvas[0][0], 'h7F8);
    check("corner_11", canvas[1][1], 'h200);
    stamp_run("far", 590, 434, 1, 0, 0, 0);
    stamp_run("outx", 591, 100, 1, 0, 0, 0);
    stamp_run("outy", 300, 42, 1, 0, 0, 0);
    stamp_run("nopen", 300, 200, 0, 0, 0, 0);
    stamp_run("stall", 199 + 14*5, 43 + 14*7, 1, 0, 3, 7*28 + 5);
    stamp_run("stall_oob", 400, 300, 1, 0, 5, 900);

    for (int i = 0; i < 25; i++) begin
      x = $urandom_range(639, 150);
      y = $urandom_range(479, 0);
      pen = ($urandom_range(3, 0) != 0);
      k = $urandom_range(5, 0);
      a = $urandom_range(1023, 0);
`ifdef CANVAS_ERASE_EN
      er = ($urandom_range(3, 0) == 0);
`else
      er = 1'b0;
`endif
      stamp_run("rnd", x, y, pen, er, k, a);
    end

    // Clear arrives on the third stamp write cycle; a read waits out the whole sweep.
    cursor_x = 10'd300;
    cursor_y = 10'd200;
    pen_down = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    model_clear();
    rif.rd_req = 1'b1;
    rif.rd_addr = 10'(5*28 + 7);
    cyc = 0;
    acks = 0;
    while (busy && cyc < 2000) begin
      if (rif.rd_ack) acks++;
      clear_req = (cyc == 100);
      @(negedge clk);
      cyc++;
    end
    clear_req = 1'b0;
    check("clr_cycles", cyc, 784);
    check("clr_no_ack", acks, 0);
    check("clr_busy_done", busy, 0);
    check("clr_pending_ack", rif.rd_ack, 1);
    @(negedge clk);
    rif.rd_req = 1'b0;
    check("clr_rd_valid", rif.rd_valid, 1);
    check("clr_rd_data", rif.rd_data, 0);
    compare_canvas("clr_canvas");

    stamp_run("post_clr", 250, 250, 1, 0, 0, 0);
    cursor_x = 10'd350;
    cursor_y = 10'd150;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    check("rst_mid_busy", busy, 0);
    compare_canvas("rst_mid_canvas");
    stamp_run("post_rst", 199 + 14*5 + 3, 43 + 14*7 + 1, 1, 0, 2, 7*28 + 5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
